// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: widths, port ids,
// FSM states and the read tag that follows a read through the memory latency.
package mem_arbiter_pkg;

    localparam int ADDR_WIDTH   = 6;
    localparam int DATA_WIDTH   = 16;
    localparam int MAX_LOCK_DEF = 4;
    localparam int MEM_DEPTH    = 1 << ADDR_WIDTH;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arbState_t;

    typedef struct packed {
        logic valid;
        logic port;
    } readTag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter. The slave modport is
// the arbiter's view; the master modport is the view of whoever drives it.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                  req0, req1;
    logic                  we0, we1;
    logic                  lock0, lock1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_in;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1, mem_in,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_we, mem_addr, mem_data
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1, mem_in,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_we, mem_addr, mem_data
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: on contention the port that did
// not win last time is chosen; a lone requester always wins.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the cpu (port 0) and the
// loader (port 1): round-robin grants, bounded bus lock, registered memory side.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF
)
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int LOCK_CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(MAX_LOCK - 1);
    localparam bit LOCK_EN = (MAX_LOCK > 1);

    arbState_t             r_state;
    arbState_t             w_stateNext;
    logic                  r_last;
    logic [LOCK_CNT_W-1:0] r_lockCnt;
    logic [LOCK_CNT_W-1:0] w_lockCntNext;
    logic [LOCK_CNT_W-1:0] w_lockCntInc;

    logic [1:0]            w_req;
    logic [1:0]            w_rrGnt;
    logic                  w_rrLock;
    logic [1:0]            w_gnt;
    logic                  w_accAny;
    logic                  w_accPort;
    logic                  w_accWe;
    logic [ADDR_WIDTH-1:0] w_accAddr;
    logic [DATA_WIDTH-1:0] w_accData;

    logic                  r_memWe;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [DATA_WIDTH-1:0] r_memData;
    readTag_t              r_tag1;
    readTag_t              r_tag2;
    logic [1:0]            r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    assign w_req        = {bus.req1, bus.req0};
    assign w_rrLock     = w_rrGnt[1] ? bus.lock1 : bus.lock0;
    assign w_lockCntInc = r_lockCnt + LOCK_CNT_W'(1);

    rr_arbiter2 u_rr (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_rrGnt)
    );

    // Grants and next state come only from requests and current state, so the
    // accept path below never loops back into this block.
    always_comb begin
        w_gnt         = 2'b00;
        w_stateNext   = r_state;
        w_lockCntNext = r_lockCnt;
        case (r_state)
            ST_IDLE: begin
                w_gnt         = w_rrGnt;
                w_lockCntNext = '0;
                if ((w_rrGnt != 2'b00) && w_rrLock && LOCK_EN) begin
                    w_stateNext = w_rrGnt[1] ? ST_OWN1 : ST_OWN0;
                end
            end
            ST_OWN0: begin
                w_gnt = {1'b0, bus.req0};
                if (!bus.req0) begin
                    w_stateNext   = ST_IDLE;
                    w_lockCntNext = '0;
                end else begin
                    w_lockCntNext = w_lockCntInc;
                    if (!bus.lock0 || (w_lockCntInc == LOCK_LAST)) begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end
            ST_OWN1: begin
                w_gnt = {bus.req1, 1'b0};
                if (!bus.req1) begin
                    w_stateNext   = ST_IDLE;
                    w_lockCntNext = '0;
                end else begin
                    w_lockCntNext = w_lockCntInc;
                    if (!bus.lock1 || (w_lockCntInc == LOCK_LAST)) begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end
            default: begin
                w_stateNext   = ST_IDLE;
                w_lockCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_last    <= PORT_LOADER;
            r_lockCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_lockCnt <= w_lockCntNext;
            if (w_accAny) begin
                r_last <= w_accPort;
            end
        end
    end

    assign w_accAny  = |w_gnt;
    assign w_accPort = w_gnt[1];
    assign w_accWe   = w_accPort ? bus.we1    : bus.we0;
    assign w_accAddr = w_accPort ? bus.addr1  : bus.addr0;
    assign w_accData = w_accPort ? bus.wdata1 : bus.wdata0;

    // Reads carry a tag for two edges so the returning mem_in word is steered
    // to the port that issued it; one accept per cycle keeps the order intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_memWe   <= 1'b0;
            r_memAddr <= '0;
            r_memData <= '0;
            r_tag1    <= '0;
            r_tag2    <= '0;
            r_rvalid  <= 2'b00;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_memWe      <= w_accAny & w_accWe;
            if (w_accAny) begin
                r_memAddr <= w_accAddr;
                r_memData <= w_accData;
            end
            r_tag1.valid <= w_accAny & ~w_accWe;
            r_tag1.port  <= w_accPort;
            r_tag2       <= r_tag1;
            r_rvalid     <= 2'b00;
            if (r_tag2.valid) begin
                if (r_tag2.port) begin
                    r_rvalid[1] <= 1'b1;
                    r_rdata1    <= bus.mem_in;
                end else begin
                    r_rvalid[0] <= 1'b1;
                    r_rdata0    <= bus.mem_in;
                end
            end
        end
    end

    assign bus.gnt0     = w_gnt[0];
    assign bus.gnt1     = w_gnt[1];
    assign bus.rvalid0  = r_rvalid[0];
    assign bus.rvalid1  = r_rvalid[1];
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;
    assign bus.mem_we   = r_memWe;
    assign bus.mem_addr = r_memAddr;
    assign bus.mem_data = r_memData;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of grants, memory and reads.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAX_LOCK     = 4;
    localparam int STARVE_BOUND = MAX_LOCK + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [DATA_WIDTH-1:0] memInitVal(input int i);
        if (i == 5) return 16'h1234;
        return DATA_WIDTH'((i * 257) ^ 23130);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory instance stand-in: synchronous, write-first, one cycle read latency.
    logic [DATA_WIDTH-1:0] tbMem [MEM_DEPTH];
    initial begin
        logic [DATA_WIDTH-1:0] rdVal;
        for (int i = 0; i < MEM_DEPTH; i++) tbMem[i] = memInitVal(i);
        forever begin
            @(posedge clk);
            rdVal = bus.mem_we ? bus.mem_data : tbMem[bus.mem_addr];
            bus.mem_in <= rdVal;
            if (bus.mem_we) tbMem[bus.mem_addr] = bus.mem_data;
        end
    end

    // Reference model: owner/tenure bookkeeping, a memory array updated in
    // accept order and a queue of reads due three negedges after acceptance.
    typedef struct {
        int                    due;
        int                    port;
        logic [DATA_WIDTH-1:0] data;
    } readExp_t;

    readExp_t              pending[$];
    logic [DATA_WIDTH-1:0] refMem [MEM_DEPTH];
    bit                    refInit    = 1'b0;
    bit                    modelValid = 1'b0;
    int                    cyc        = 0;
    int                    owner      = -1;
    int                    tenure     = 0;
    int                    lastPort   = 1;
    int                    waitCnt [2];
    logic                  expMemWe;
    logic [ADDR_WIDTH-1:0] expMemAddr;
    logic [DATA_WIDTH-1:0] expMemData;
    logic                  expRvalid [2];
    logic [DATA_WIDTH-1:0] expRdata [2];

    always @(negedge clk) begin
        logic [1:0]            req, lck, wr, expGnt, acc;
        logic [ADDR_WIDTH-1:0] ad [2];
        logic [DATA_WIDTH-1:0] wd [2];
        readExp_t              e;
        int                    p;
        if (!refInit) begin
            for (int i = 0; i < MEM_DEPTH; i++) refMem[i] = memInitVal(i);
            refInit = 1'b1;
        end
        cyc++;
        req   = {bus.req1, bus.req0};
        lck   = {bus.lock1, bus.lock0};
        wr    = {bus.we1, bus.we0};
        ad[0] = bus.addr0;  ad[1] = bus.addr1;
        wd[0] = bus.wdata0; wd[1] = bus.wdata1;
        expGnt = 2'b00;
        if (owner < 0) begin
            if (req == 2'b11) expGnt = (lastPort == 0) ? 2'b10 : 2'b01;
            else expGnt = req;
        end else if (req[owner]) begin
            expGnt = (owner == 0) ? 2'b01 : 2'b10;
        end
        if (modelValid) begin
            expRvalid[0] = 1'b0;
            expRvalid[1] = 1'b0;
            if (pending.size() > 0 && pending[0].due == cyc) begin
                expRvalid[pending[0].port] = 1'b1;
                expRdata[pending[0].port]  = pending[0].data;
                void'(pending.pop_front());
            end
            checkOutput("rvalid0", bus.rvalid0, expRvalid[0]);
            checkOutput("rvalid1", bus.rvalid1, expRvalid[1]);
            checkOutput("rdata0", bus.rdata0, expRdata[0]);
            checkOutput("rdata1", bus.rdata1, expRdata[1]);
            checkOutput("mem_we", bus.mem_we, expMemWe);
            checkOutput("mem_addr", bus.mem_addr, expMemAddr);
            checkOutput("mem_data", bus.mem_data, expMemData);
            if (!rst) checkOutput("gnt", {bus.gnt1, bus.gnt0}, expGnt);
        end
        if (rst) begin
            modelValid = 1'b1;
            owner      = -1;
            tenure     = 0;
            lastPort   = 1;
            pending.delete();
            expMemWe   = 1'b0;
            expMemAddr = '0;
            expMemData = '0;
            expRdata[0] = '0;
            expRdata[1] = '0;
            waitCnt[0] = 0;
            waitCnt[1] = 0;
        end else if (modelValid) begin
            acc = req & expGnt;
            for (int q = 0; q < 2; q++) begin
                if (acc[q]) begin
                    checkOutput($sformatf("starve%0d", q), waitCnt[q] <= STARVE_BOUND, 1);
                    waitCnt[q] = 0;
                end else if (req[q]) begin
                    waitCnt[q]++;
                end else begin
                    waitCnt[q] = 0;
                end
            end
            if (acc != 2'b00) begin
                p = acc[1] ? 1 : 0;
                lastPort   = p;
                expMemWe   = wr[p];
                expMemAddr = ad[p];
                expMemData = wd[p];
                if (wr[p]) begin
                    refMem[ad[p]] = wd[p];
                end else begin
                    e.due  = cyc + 3;
                    e.port = p;
                    e.data = refMem[ad[p]];
                    pending.push_back(e);
                end
                if (owner < 0) begin
                    if (lck[p] && MAX_LOCK > 1) begin
                        owner  = p;
                        tenure = 1;
                    end
                end else begin
                    tenure++;
                    if (!lck[p] || tenure >= MAX_LOCK) owner = -1;
                end
            end else begin
                expMemWe = 1'b0;
                if (owner >= 0 && !req[owner]) owner = -1;
            end
        end
    end

    bit recordRv = 1'b0;
    int rvOrder[$];
    always @(negedge clk) begin
        if (recordRv) begin
            if (bus.rvalid0) rvOrder.push_back(0);
            if (bus.rvalid1) rvOrder.push_back(1);
        end
    end

    task automatic applyStimulus(
        input logic r0, input logic w0, input logic l0,
        input logic [ADDR_WIDTH-1:0] a0, input logic [DATA_WIDTH-1:0] d0,
        input logic r1, input logic w1, input logic l1,
        input logic [ADDR_WIDTH-1:0] a1, input logic [DATA_WIDTH-1:0] d1);
        bus.req0 = r0; bus.we0 = w0; bus.lock0 = l0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.lock1 = l1; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        stepEdge();
        rst = 1'b1;
        stepEdge();
        rst = 1'b0;
    endtask

    logic                  rq [2], wrq [2], lk [2];
    logic [ADDR_WIDTH-1:0] adr [2];
    logic [DATA_WIDTH-1:0] dat [2];
    logic [1:0]            accNow;

    initial begin
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        rst = 1'b1;
        repeat (2) stepEdge();
        rst = 1'b0;

        // Reset values and a single cpu read of address 5.
        applyStimulus(1, 0, 0, 6'd5, '0, 0, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("t1 reset mem_we", bus.mem_we, 0);
        checkOutput("t1 reset rvalid0", bus.rvalid0, 0);
        checkOutput("t1 gnt", {bus.gnt1, bus.gnt0}, 2'b01);
        stepEdge();
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("t1 mem_addr", bus.mem_addr, 5);
        checkOutput("t1 gnt1", bus.gnt1, 0);
        @(negedge clk);
        checkOutput("t1 early rvalid0", bus.rvalid0, 0);
        @(negedge clk);
        checkOutput("t1 rvalid0", bus.rvalid0, 1);
        checkOutput("t1 rdata0", bus.rdata0, 16'h1234);

        // Unlocked contention alternates, and read data returns in grant order.
        pulseReset();
        rvOrder.delete();
        recordRv = 1'b1;
        applyStimulus(1, 0, 0, 6'd1, '0, 1, 0, 0, 6'd2, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t2 grant%0d", i), {bus.gnt1, bus.gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            stepEdge();
        end
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (4) @(negedge clk);
        recordRv = 1'b0;
        checkOutput("t2 rv count", rvOrder.size(), 4);
        for (int i = 0; i < rvOrder.size(); i++) begin
            checkOutput($sformatf("t2 rv order%0d", i), rvOrder[i], i % 2);
        end

        // Locked cpu keeps the bus for exactly MAX_LOCK accepts.
        pulseReset();
        applyStimulus(1, 0, 1, 6'd3, '0, 1, 0, 0, 6'd4, '0);
        for (int i = 0; i < MAX_LOCK + 1; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t3 grant%0d", i), {bus.gnt1, bus.gnt0}, (i < MAX_LOCK) ? 2'b01 : 2'b10);
            stepEdge();
        end
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (4) @(negedge clk);
        stepEdge();

        // Loader write then read of the same address.
        applyStimulus(0, 0, 0, '0, '0, 1, 1, 0, 6'd9, 16'hBEEF);
        @(negedge clk);
        checkOutput("t4 gnt", {bus.gnt1, bus.gnt0}, 2'b10);
        stepEdge();
        applyStimulus(0, 0, 0, '0, '0, 1, 0, 0, 6'd9, '0);
        @(negedge clk);
        checkOutput("t4 mem_we", bus.mem_we, 1);
        checkOutput("t4 mem_addr", bus.mem_addr, 9);
        checkOutput("t4 mem_data", bus.mem_data, 16'hBEEF);
        stepEdge();
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("t4 mem_we low", bus.mem_we, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4 rvalid1", bus.rvalid1, 1);
        checkOutput("t4 rdata1", bus.rdata1, 16'hBEEF);
        stepEdge();

        // Reset right after a read accept drops the read.
        applyStimulus(1, 0, 1, 6'd3, '0, 0, 0, 0, '0, '0);
        stepEdge();
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        rst = 1'b1;
        stepEdge();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t5 rvalid0 %0d", i), bus.rvalid0, 0);
            if (i == 0) begin
                checkOutput("t5 mem_addr", bus.mem_addr, 0);
                checkOutput("t5 rdata0", bus.rdata0, 0);
            end
        end
        stepEdge();
        applyStimulus(1, 0, 0, 6'd7, '0, 1, 0, 0, 6'd8, '0);
        @(negedge clk);
        checkOutput("t5 first contention", {bus.gnt1, bus.gnt0}, 2'b01);
        stepEdge();
        applyStimulus(0, 0, 0, '0, '0, 1, 0, 0, 6'd8, '0);
        stepEdge();
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (4) stepEdge();

        // Random traffic with occasional resets.
        for (int q = 0; q < 2; q++) begin
            rq[q] = 1'b0; wrq[q] = 1'b0; lk[q] = 1'b0; adr[q] = '0; dat[q] = '0;
        end
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            accNow = rst ? 2'b00 : {bus.req1 & bus.gnt1, bus.req0 & bus.gnt0};
            stepEdge();
            rst = (c % 500 == 499);
            for (int q = 0; q < 2; q++) begin
                if (!rq[q] || accNow[q]) begin
                    rq[q]  = ($urandom_range(0, 99) < 60);
                    wrq[q] = $urandom_range(0, 1) == 1;
                    lk[q]  = $urandom_range(0, 3) == 0;
                    adr[q] = ADDR_WIDTH'($urandom_range(0, 15));
                    dat[q] = DATA_WIDTH'($urandom);
                end
            end
            applyStimulus(rq[0], wrq[0], lk[0], adr[0], dat[0], rq[1], wrq[1], lk[1], adr[1], dat[1]);
        end
        rst = 1'b0;
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (6) stepEdge();
        checkOutput("drain pending reads", pending.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
